// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency backing memory between instruction fetch and
// the load/store port; data has priority, bounded by a fetch-starvation streak.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MAX_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STREAK_SAT = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              bus_err_q;
  logic [SW-1:0]     streak_q;
  logic [TW-1:0]     tcnt_q;

  // Data wins a tie unless fetch has already lost MAX_STREAK times in a row.
  logic pick_d;
  assign pick_d = d_req && !(if_req && (streak_q == STREAK_SAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      streak_q    <= '0;
      tcnt_q      <= '0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!if_req) streak_q <= '0;
          if (if_req || d_req) begin
            mem_req_q <= 1'b1;
            tcnt_q    <= '0;
            if (pick_d) begin
              state_q     <= BUSY_D;
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              if (if_req && (streak_q != STREAK_SAT)) streak_q <= streak_q + 1'b1;
            end else begin
              state_q     <= BUSY_I;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              streak_q    <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // An ack on the final timeout cycle still completes normally.
          if (mem_ack || (tcnt_q == TO_LAST)) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (!mem_ack) bus_err_q <= 1'b1;
            if (state_q == BUSY_I) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= mem_ack ? mem_rdata : '0;
            end else begin
              d_done_q  <= 1'b1;
              d_rdata_q <= (mem_ack && !mem_we_q) ? mem_rdata : '0;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign bus_err   = bus_err_q;
  assign if_stall  = if_req & ~if_done_q;
  assign d_stall   = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a memory model checks issued
// transactions, a monitor checks completion pulses against queued expectations.
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'h8C480004;  // model read data = addr ^ K

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata;
  logic        if_done, if_stall, d_done, d_stall;
  logic        mem_req, mem_we, mem_ack, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack_m, mem_ack_s;

  assign mem_ack = mem_ack_m | mem_ack_s;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_d; logic [31:0] data; } resp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } mreq_t;

  resp_t exp_q[$];
  mreq_t exp_mem[$];
  int    checks   = 0;
  int    failures = 0;
  int    lat      = 2;
  bit    ack_en   = 1'b1;
  bit    mdl_busy = 1'b0;
  int    mdl_n    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: checks each new request, acks lat cycles after mem_req rises.
  initial begin
    mem_ack_m = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset || !mem_req) begin
        mdl_busy  = 1'b0;
        mem_ack_m = 1'b0;
      end else begin
        if (!mdl_busy) begin
          mreq_t m;
          mdl_busy = 1'b1;
          mdl_n    = 0;
          if (exp_mem.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mem_req: got addr 0x%08h expected none", mem_addr);
          end else begin
            m = exp_mem.pop_front();
            chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
            chk("mem_addr", mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          end
        end
        if (ack_en && mdl_n == lat - 1) begin
          mem_ack_m = 1'b1;
          mem_rdata = mem_addr ^ K;
        end else begin
          mem_ack_m = 1'b0;
        end
        mdl_n++;
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (!reset && (if_done || d_done)) begin
      if (if_done && d_done) begin
        checks++; failures++;
        $display("FAIL both_done: got if_done=1 d_done=1 expected one");
      end else if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done: got if_done=%0b d_done=%0b expected none", if_done, d_done);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("done_port", {31'b0, d_done}, {31'b0, e.is_d});
        if (if_done) begin
          chk("if_rdata", if_rdata, e.data);
          chk("if_stall_done", {31'b0, if_stall}, 32'd0);
        end else begin
          chk("d_rdata", d_rdata, e.data);
          chk("d_stall_done", {31'b0, d_stall}, 32'd0);
        end
      end
    end
  end

  task automatic wait_if();
    int c = 0;
    do begin @(negedge clk); c++; end while (!if_done && c < 300);
    chk("if_done_seen", {31'b0, if_done}, 32'd1);
  endtask

  task automatic wait_d();
    int c = 0;
    do begin @(negedge clk); c++; end while (!d_done && c < 300);
    chk("d_done_seen", {31'b0, d_done}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] a);
    if_addr = a;
    if_req  = 1'b1;
    #1 chk("if_stall_wait", {31'b0, if_stall}, 32'd1);
    wait_if();
    if_req = 1'b0;
  endtask

  task automatic daccess(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    wait_d();
    d_req = 1'b0;
  endtask

  task automatic d_stream(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      d_we = 1'b0; d_addr = base + 32'(4 * k); d_req = 1'b1;
      wait_d();
    end
    d_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; mem_ack_s = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_if_done", {31'b0, if_done}, 32'd0);
    chk("rst_d_done", {31'b0, d_done}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, then a load to make d_rdata non-zero.
    lat = 2;
    exp_mem.push_back('{1'b0, 32'h00400004, 32'h0});
    exp_q.push_back('{1'b0, 32'h8C080000});
    fetch(32'h00400004);
    exp_mem.push_back('{1'b0, 32'h00000020, 32'h0});
    exp_q.push_back('{1'b1, 32'h8C480024});
    daccess(1'b0, 32'h20, 32'h0);
    @(negedge clk);

    // Simultaneous store + fetch: data first.
    exp_mem.push_back('{1'b1, 32'h00000010, 32'hA5A5A5A5});
    exp_mem.push_back('{1'b0, 32'h00400008, 32'h0});
    exp_q.push_back('{1'b1, 32'h0});
    exp_q.push_back('{1'b0, 32'h8C08000C});
    fork
      fetch(32'h00400008);
      daccess(1'b1, 32'h10, 32'hA5A5A5A5);
    join
    @(negedge clk);

    // Starvation guard: D,D,D,D,I,D.
    lat = 1;
    exp_mem.push_back('{1'b0, 32'h100, 32'h0});
    exp_mem.push_back('{1'b0, 32'h104, 32'h0});
    exp_mem.push_back('{1'b0, 32'h108, 32'h0});
    exp_mem.push_back('{1'b0, 32'h10C, 32'h0});
    exp_mem.push_back('{1'b0, 32'h2000, 32'h0});
    exp_mem.push_back('{1'b0, 32'h110, 32'h0});
    exp_q.push_back('{1'b1, 32'h8C480104});
    exp_q.push_back('{1'b1, 32'h8C480100});
    exp_q.push_back('{1'b1, 32'h8C48010C});
    exp_q.push_back('{1'b1, 32'h8C480108});
    exp_q.push_back('{1'b0, 32'h8C482004});
    exp_q.push_back('{1'b1, 32'h8C480114});
    fork
      fetch(32'h2000);
      d_stream(32'h100, 5);
    join
    @(negedge clk);

    // Ack on the last allowed cycle completes normally.
    lat = 64;
    exp_mem.push_back('{1'b0, 32'h200, 32'h0});
    exp_q.push_back('{1'b1, 32'h8C480204});
    daccess(1'b0, 32'h200, 32'h0);
    chk("bus_err_boundary", {31'b0, bus_err}, 32'd0);
    @(negedge clk);

    // Timeout: no ack at all.
    ack_en = 1'b0;
    exp_mem.push_back('{1'b0, 32'h40, 32'h0});
    exp_q.push_back('{1'b1, 32'h0});
    d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
    for (int c = 0; c < 20 && !mem_req; c++) begin @(posedge clk); #1; end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (mem_req && n < 200);
    chk("timeout_len", n, 32'd64);
    wait_d();
    d_req = 1'b0;
    chk("bus_err_set", {31'b0, bus_err}, 32'd1);
    ack_en = 1'b1;
    lat = 2;
    exp_mem.push_back('{1'b0, 32'h3000, 32'h0});
    exp_q.push_back('{1'b0, 32'h8C483004});
    fetch(32'h3000);
    chk("bus_err_sticky", {31'b0, bus_err}, 32'd1);
    @(negedge clk);

    // Reset one cycle into BUSY.
    lat = 20;
    exp_mem.push_back('{1'b0, 32'h80, 32'h0});
    d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    for (int c = 0; c < 20 && !mem_req; c++) begin @(posedge clk); #1; end
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Late / spurious ack in IDLE must be ignored.
    @(posedge clk); #1 mem_ack_s = 1'b1;
    @(posedge clk); #1 mem_ack_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
    chk("spur_d_done", {31'b0, d_done}, 32'd0);

    lat = 2;
    exp_mem.push_back('{1'b0, 32'h00400004, 32'h0});
    exp_q.push_back('{1'b0, 32'h8C080000});
    fetch(32'h00400004);
    repeat (3) @(negedge clk);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("exp_mem_drained", exp_mem.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
